// File: rtl/bcd_pkg.sv
// Shared BCD conversion package: FSM state type, digit type and limits.
// Used by both the BCD-to-binary input converter and the binary-to-BCD
// output converter so the top-level FSM drives both with the same states.
package bcd_pkg;

    // Converter FSM states, common to input and output converters
    typedef enum logic [1:0] {
        e_idle      = 2'd0,
        e_operation = 2'd1,
        e_done      = 2'd2
    } t_state;

    localparam int N_DIGITS = 4;
    localparam int BCD_MAX  = 9999;

    typedef logic [3:0] t_bcd_digit;

endpackage : bcd_pkg

// File: rtl/bcd_dig_adj.sv
// Double-dabble digit correction: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
import bcd_pkg::*;

module bcd_dig_adj (
    input  t_bcd_digit i_dig,
    output t_bcd_digit o_dig
);

    // 4-bit add, any carry-out is dropped (cannot occur for legal digits)
    assign o_dig = (i_dig >= 4'd5) ? t_bcd_digit'(i_dig + 4'd3) : i_dig;

endmodule : bcd_dig_adj

// File: rtl/bin14_to_bcd4.sv
// bin14_to_bcd4: sequential binary-to-BCD converter, one bit per clock
// (shift-and-add-3). Produces four decimal digits for the display path.
//
// Handshake: i_start is accepted only when o_ready=1 (state e_idle); i_bin is
// sampled on that same edge. o_done is a one-cycle pulse (state e_done) on the
// cycle the digit/overflow registers first hold the new result; they hold it
// until the next o_done. Starts while busy are ignored.
//
// Optional feature macro: BIN2BCD_OVF_SAT_EN
//   defined   : operands > 9999 raise o_ovf and force all digits to 9.
//   undefined : no compare logic, o_ovf = 0, digits show operand mod 10000.
import bcd_pkg::*;

module bin14_to_bcd4 #(
    parameter int W_BIN = 14
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [W_BIN-1:0] i_bin,
    output logic             o_ready,
    output logic             o_done,
    output t_bcd_digit       o_bcd3,
    output t_bcd_digit       o_bcd2,
    output t_bcd_digit       o_bcd1,
    output t_bcd_digit       o_bcd0,
    output logic             o_ovf,
    output t_state           o_state
);

    // Reject unsupported widths at elaboration time
    if (W_BIN < 4 || W_BIN > 16) begin : g_bad_width
        $error("bin14_to_bcd4: W_BIN must be in 4..16");
    end

    localparam int IDX_W = 5;

    t_state             state;
    logic [IDX_W-1:0]   idx;
    logic [W_BIN-1:0]   sr;
    logic [15:0]        bcd;
    logic [15:0]        bcd_adj;

    // Per-digit +3 correction applied before every shift
    for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
        bcd_dig_adj u_adj (
            .i_dig (bcd[4*g +: 4]),
            .o_dig (bcd_adj[4*g +: 4])
        );
    end

`ifdef BIN2BCD_OVF_SAT_EN
    logic ovf_cmp;
    logic ovf_lat;

    // Overflow compare done once, on the capture edge
    assign ovf_cmp = ({{(32-W_BIN){1'b0}}, i_bin} > 32'(BCD_MAX));
`else
    assign o_ovf = 1'b0;
`endif

    // Conversion FSM with shift register, working BCD register and outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= e_idle;
            idx     <= '0;
            sr      <= '0;
            bcd     <= '0;
            o_bcd3  <= '0;
            o_bcd2  <= '0;
            o_bcd1  <= '0;
            o_bcd0  <= '0;
`ifdef BIN2BCD_OVF_SAT_EN
            ovf_lat <= 1'b0;
            o_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                e_idle: begin
                    if (i_start) begin
                        sr      <= i_bin;
                        bcd     <= '0;
                        idx     <= IDX_W'(W_BIN);
`ifdef BIN2BCD_OVF_SAT_EN
                        ovf_lat <= ovf_cmp;
`endif
                        state   <= e_operation;
                    end
                end
                e_operation: begin
                    if (idx == '0) begin
`ifdef BIN2BCD_OVF_SAT_EN
                        if (ovf_lat) begin
                            o_bcd3 <= 4'd9;
                            o_bcd2 <= 4'd9;
                            o_bcd1 <= 4'd9;
                            o_bcd0 <= 4'd9;
                        end else begin
                            o_bcd3 <= bcd[15:12];
                            o_bcd2 <= bcd[11:8];
                            o_bcd1 <= bcd[7:4];
                            o_bcd0 <= bcd[3:0];
                        end
                        o_ovf <= ovf_lat;
`else
                        o_bcd3 <= bcd[15:12];
                        o_bcd2 <= bcd[11:8];
                        o_bcd1 <= bcd[7:4];
                        o_bcd0 <= bcd[3:0];
`endif
                        state <= e_done;
                    end else begin
                        // Thousands carry-out falls off the top: result is mod 10000
                        bcd   <= {bcd_adj[14:0], sr[W_BIN-1]};
                        sr    <= {sr[W_BIN-2:0], 1'b0};
                        idx   <= idx - 1'b1;
                    end
                end
                e_done: begin
                    state <= e_idle;
                end
                default: begin
                    state <= e_idle;
                end
            endcase
        end
    end

    // Handshake flags decoded straight from the state register
    assign o_ready = (state == e_idle);
    assign o_done  = (state == e_done);
    assign o_state = state;

endmodule : bin14_to_bcd4

// File: tb/tb_bin14_to_bcd4.sv
// Testbench for bin14_to_bcd4: directed vectors, scoreboard queue of
// expected {done cycle, ovf, digits}, monitor that pops on every o_done.
import bcd_pkg::*;

module tb_bin14_to_bcd4;

    localparam int W     = 14;
    localparam int EXP_W = 49;   // [48:17] done cycle, [16] ovf, [15:0] digits

    logic         i_clk;
    logic         i_rst;
    logic         i_start;
    logic [W-1:0] i_bin;
    logic         o_ready;
    logic         o_done;
    logic [3:0]   o_bcd3, o_bcd2, o_bcd1, o_bcd0;
    logic         o_ovf;
    t_state       o_state;

    logic [EXP_W-1:0] exp_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    bin14_to_bcd4 #(.W_BIN(W)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_bin   (i_bin),
        .o_ready (o_ready),
        .o_done  (o_done),
        .o_bcd3  (o_bcd3),
        .o_bcd2  (o_bcd2),
        .o_bcd1  (o_bcd1),
        .o_bcd0  (o_bcd0),
        .o_ovf   (o_ovf),
        .o_state (o_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: decimal digits of the operand (saturated if enabled)
    function automatic logic [16:0] ref_model(input int v);
        int m;
`ifdef BIN2BCD_OVF_SAT_EN
        if (v > 9999) return {1'b1, 16'h9999};
`endif
        m = v % 10000;
        return {1'b0, 4'(m / 1000), 4'((m / 100) % 10), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    // Driver: wait for ready (at negedge), issue one start, push expectation
    task automatic issue(input logic [W-1:0] v, input logic [16:0] e);
        int t;
        int k;
        t = 0;
        while (!o_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (!o_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL ready_timeout: got ready=%0b expected 1", o_ready);
        end
        k = cyc;
        i_start = 1'b1;
        i_bin   = v;
        exp_q.push_back({32'(k + W + 2), e});
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(negedge i_clk);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge i_clk) begin
        logic [EXP_W-1:0] e;
        logic [EXP_W-1:0] a;
        if (o_done) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = exp_q.pop_front();
                a = {32'(cyc), o_ovf, o_bcd3, o_bcd2, o_bcd1, o_bcd0};
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL result: got cyc=%0d ovf=%0b bcd=%h expected cyc=%0d ovf=%0b bcd=%h",
                             a[48:17], a[16], a[15:0], e[48:17], e[16], e[15:0]);
                end
            end
        end
    end

    // ---------------- directed vectors ----------------
    localparam int N_VEC = 9;
    logic [W-1:0] vec_bin [N_VEC] = '{14'd1234, 14'd0, 14'd9999, 14'd5, 14'd10,
                                       14'd4096, 14'd8191, 14'd10000, 14'd16383};
`ifdef BIN2BCD_OVF_SAT_EN
    logic [16:0]  vec_exp [N_VEC] = '{17'h01234, 17'h00000, 17'h09999, 17'h00005, 17'h00010,
                                       17'h04096, 17'h08191, 17'h19999, 17'h19999};
`else
    logic [16:0]  vec_exp [N_VEC] = '{17'h01234, 17'h00000, 17'h09999, 17'h00005, 17'h00010,
                                       17'h04096, 17'h08191, 17'h00000, 17'h06383};
`endif

    // ---------------- main stimulus ----------------
    initial begin
        int k;
        int v;
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_bin   = '0;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Reset state
        chk("rst_digits", 32'({o_bcd3, o_bcd2, o_bcd1, o_bcd0}), 32'h0);
        chk("rst_ovf",    32'(o_ovf),   32'd0);
        chk("rst_ready",  32'(o_ready), 32'd1);
        chk("rst_done",   32'(o_done),  32'd0);

        // Directed table
        for (int i = 0; i < N_VEC; i++) begin
            issue(vec_bin[i], vec_exp[i]);
            wait_drain();
        end

        // Mid-conversion start is ignored; outputs hold during operation
        issue(14'd9999, 17'h09999);
        wait_drain();
        issue(14'd1234, 17'h01234);
        repeat (4) @(negedge i_clk);
        chk("busy_ready", 32'(o_ready), 32'd0);
        chk("hold_digits", 32'({o_bcd3, o_bcd2, o_bcd1, o_bcd0}), 32'h9999);
        i_start = 1'b1;
        i_bin   = 14'd4321;
        @(negedge i_clk);
        i_start = 1'b0;
        wait_drain();

        // Back-to-back with start held high: done pulses 17 cycles apart
        while (!o_ready) @(negedge i_clk);
        k = cyc;
        i_start = 1'b1;
        i_bin   = 14'd3141;
        exp_q.push_back({32'(k + W + 2), 17'h03141});
        exp_q.push_back({32'(k + W + 2 + W + 3), 17'h08765});
        @(negedge i_clk);
        i_bin = 14'd8765;
        repeat (17) @(negedge i_clk);
        i_start = 1'b0;
        wait_drain();

        // Reset at shift 7 of 5678: immediate clear, no done
        while (!o_ready) @(negedge i_clk);
        i_start = 1'b1;
        i_bin   = 14'd5678;
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (7) @(negedge i_clk);
        i_rst = 1'b1;
        #1;
        chk("midrst_digits", 32'({o_bcd3, o_bcd2, o_bcd1, o_bcd0}), 32'h0);
        chk("midrst_ovf",    32'(o_ovf),   32'd0);
        chk("midrst_ready",  32'(o_ready), 32'd1);
        chk("midrst_done",   32'(o_done),  32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (20) @(negedge i_clk);
        issue(14'd42, 17'h00042);
        wait_drain();

        // Strided sweep and a few random operands against the reference model
        for (int s = 0; s < 16384; s += 97) begin
            issue(W'(s), ref_model(s));
        end
        issue(14'd16383, ref_model(16383));
        for (int r = 0; r < 8; r++) begin
            v = $urandom_range(16383, 0);
            issue(W'(v), ref_model(v));
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_bin14_to_bcd4
